// File: rtl/traffic_sequencer.sv
// traffic_sequencer: programmable phase table stepped on a 1 ms tick with pause, skip, trim and flicker
// Ports: clk/reset_n (async active-low); tick, pause, next_req, adj_inc/adj_dec control timing;
// wr_* write one table entry; last_wr/last_data set the final phase index;
// phase, remaining, cur_dur, lights, phase_start, paused report the running state.
module traffic_sequencer #(
  parameter int N_PHASES      = 16,
  parameter int LIGHT_W       = 10,
  parameter int DUR_W         = 6,
  parameter int TICKS_PER_SEC = 1000,
  parameter int FLICKER_TICKS = 125,
  localparam int PW = $clog2(N_PHASES)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick,
  input  logic               pause,
  input  logic               next_req,
  input  logic               adj_inc,
  input  logic               adj_dec,
  input  logic               wr_en,
  input  logic [PW-1:0]      wr_addr,
  input  logic [DUR_W-1:0]   wr_dur,
  input  logic [LIGHT_W-1:0] wr_on,
  input  logic [LIGHT_W-1:0] wr_off,
  input  logic               last_wr,
  input  logic [PW-1:0]      last_data,
  output logic [PW-1:0]      phase,
  output logic [DUR_W-1:0]   remaining,
  output logic [DUR_W-1:0]   cur_dur,
  output logic [LIGHT_W-1:0] lights,
  output logic               phase_start,
  output logic               paused
);
  localparam int SW = $clog2(TICKS_PER_SEC + 1);
  localparam int FW = $clog2(FLICKER_TICKS + 1);
  typedef enum logic [1:0] {INIT, RUN, HOLD} state_t;
  state_t state;
  logic [DUR_W-1:0]   dur_t [N_PHASES];
  logic [LIGHT_W-1:0] on_t  [N_PHASES];
  logic [LIGHT_W-1:0] off_t [N_PHASES];
  logic [PW-1:0]      last_phase, nxt, load_idx;
  logic [SW-1:0]      subsec;
  logic [FW-1:0]      flick_cnt;
  logic               flick, sec, active, clamp, adv, wr_hit, trim, cap_en, flick_wrap;
  logic [DUR_W-1:0]   trim_dur, new_cap, rem_run, rem_n;
  // A stored duration of 0 still runs for one second.
  function automatic logic [DUR_W-1:0] eff(input logic [DUR_W-1:0] d);
    return d == '0 ? DUR_W'(1) : d;
  endfunction
  assign cur_dur = dur_t[phase];
  always_comb begin
    sec        = tick && subsec == SW'(TICKS_PER_SEC - 1);
    active     = state == RUN || state == HOLD;
    // Shrinking the sequence below the current phase restarts from entry 0.
    clamp      = active && phase > last_phase;
    adv        = active && !clamp && (next_req || (state == RUN && sec && remaining <= DUR_W'(1)));
    nxt        = phase == last_phase ? '0 : phase + PW'(1);
    load_idx   = clamp ? '0 : nxt;
    wr_hit     = wr_en && wr_addr == phase;
    trim       = !wr_hit && (adj_inc ^ adj_dec);
    trim_dur   = adj_inc ? (cur_dur == {DUR_W{1'b1}} ? cur_dur : cur_dur + DUR_W'(1))
                         : (cur_dur <= DUR_W'(1) ? DUR_W'(1) : cur_dur - DUR_W'(1));
    new_cap    = wr_hit ? eff(wr_dur) : trim_dur;
    cap_en     = wr_hit || trim;
    rem_run    = (state == RUN && sec) ? remaining - DUR_W'(1) : remaining;
    rem_n      = (cap_en && new_cap < rem_run) ? new_cap : rem_run;
    flick_wrap = flick_cnt == FW'(FLICKER_TICKS - 1);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_PHASES; i++) begin
        dur_t[i] <= '0;
        on_t[i]  <= '0;
        off_t[i] <= '0;
      end
      last_phase  <= PW'(N_PHASES - 1);
      subsec      <= '0;
      flick_cnt   <= '0;
      flick       <= 1'b0;
      phase       <= '0;
      remaining   <= '0;
      lights      <= '0;
      phase_start <= 1'b0;
      paused      <= 1'b0;
      state       <= INIT;
    end else begin
      phase_start <= 1'b0;
      if (wr_en) begin
        dur_t[wr_addr] <= wr_dur;
        on_t[wr_addr]  <= wr_on;
        off_t[wr_addr] <= wr_off;
      end
      if (trim) dur_t[phase] <= trim_dur;
      if (last_wr) last_phase <= last_data > PW'(N_PHASES - 1) ? PW'(N_PHASES - 1) : last_data;
      if (state != HOLD && tick) subsec <= sec ? '0 : subsec + SW'(1);
      if (active && tick) begin
        flick_cnt <= flick_wrap ? '0 : flick_cnt + FW'(1);
        if (flick_wrap) flick <= ~flick;
      end
      lights <= flick ? off_t[phase] : on_t[phase];
      if (state == INIT) begin
        phase       <= '0;
        remaining   <= eff(dur_t[0]);
        subsec      <= '0;
        phase_start <= 1'b1;
      end else if (clamp || adv) begin
        phase       <= load_idx;
        remaining   <= eff(dur_t[load_idx]);
        subsec      <= '0;
        flick       <= 1'b0;
        flick_cnt   <= '0;
        phase_start <= 1'b1;
      end else begin
        remaining <= rem_n;
      end
      state  <= (state != INIT && pause) ? HOLD : RUN;
      paused <= state != INIT && pause;
    end
  end
endmodule

// File: tb/tb_traffic_sequencer.sv
// tb_traffic_sequencer: directed checks of sequencing, flicker, pause, trim, sequence length and reset
module tb_traffic_sequencer;
  logic       clk = 0, reset_n = 0, tick = 0, pause = 0, next_req = 0;
  logic       adj_inc = 0, adj_dec = 0, wr_en = 0, last_wr = 0;
  logic [3:0] wr_addr = 0, last_data = 0;
  logic [5:0] wr_dur = 0;
  logic [9:0] wr_on = 0, wr_off = 0;
  logic [3:0] phase;
  logic [5:0] remaining, cur_dur;
  logic [9:0] lights;
  logic       phase_start, paused;
  int         n_tests = 0, n_fail = 0;

  traffic_sequencer dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .pause(pause), .next_req(next_req),
    .adj_inc(adj_inc), .adj_dec(adj_dec), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_dur(wr_dur), .wr_on(wr_on), .wr_off(wr_off), .last_wr(last_wr),
    .last_data(last_data), .phase(phase), .remaining(remaining), .cur_dur(cur_dur),
    .lights(lights), .phase_start(phase_start), .paused(paused)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    tick = 1;
    repeat (n) step();
    tick = 0;
  endtask

  task automatic pulse_next();
    next_req = 1;
    step();
    next_req = 0;
  endtask

  task automatic write(input logic [3:0] a, input logic [5:0] d, input logic [9:0] on, input logic [9:0] off);
    wr_addr = a; wr_dur = d; wr_on = on; wr_off = off; wr_en = 1;
    step();
    wr_en = 0;
  endtask

  task automatic adj(input logic i, input logic d);
    adj_inc = i; adj_dec = d;
    step();
    adj_inc = 0; adj_dec = 0;
  endtask

  task automatic set_last(input logic [3:0] d);
    last_data = d; last_wr = 1;
    step();
    last_wr = 0;
  endtask

  initial begin
    #12;
    check("rst_phase", phase, 0);
    check("rst_rem", remaining, 0);
    check("rst_lights", lights, 0);
    check("rst_ps", phase_start, 0);
    check("rst_paused", paused, 0);
    reset_n = 1;
    step();
    check("init_ps", phase_start, 1);
    check("init_rem", remaining, 1);
    // table: durations 3,0,2
    write(0, 3, 10'h0B2, 10'h092);
    write(1, 0, 10'h0B2, 10'h092);
    write(2, 2, 10'h0B2, 10'h092);
    set_last(2);
    pulse_next();
    check("skip1_phase", phase, 1);
    pulse_next();
    check("skip2_rem", remaining, 2);
    pulse_next();
    check("wrap_phase", phase, 0);
    check("wrap_rem", remaining, 3);
    check("wrap_ps", phase_start, 1);
    run_ticks(999);
    check("p0_999_rem", remaining, 3);
    check("p0_999_lights", lights, 10'h092);
    run_ticks(1);
    check("p0_1000_rem", remaining, 2);
    run_ticks(1000);
    check("p0_2000_rem", remaining, 1);
    run_ticks(999);
    check("p0_2999_phase", phase, 0);
    run_ticks(1);
    check("p1_phase", phase, 1);
    check("p1_ps", phase_start, 1);
    check("p1_rem", remaining, 1);
    run_ticks(1000);
    check("p2_phase", phase, 2);
    check("p2_ps", phase_start, 1);
    check("p2_rem", remaining, 2);
    run_ticks(1999);
    check("p2_1999_rem", remaining, 1);
    run_ticks(1);
    check("p0b_phase", phase, 0);
    check("p0b_ps", phase_start, 1);
    check("p0b_rem", remaining, 3);
    // flicker
    write(0, 3, 10'h3FF, 10'h000);
    run_ticks(124);
    check("flk_on1", lights, 10'h3FF);
    run_ticks(2);
    check("flk_off1", lights, 10'h000);
    run_ticks(125);
    check("flk_on2", lights, 10'h3FF);
    run_ticks(126);
    check("flk_off2", lights, 10'h000);
    pulse_next();
    step();
    check("flk_p1_on", lights, 10'h0B2);
    pulse_next();
    pulse_next();
    step();
    check("flk_p0_on", lights, 10'h3FF);
    check("flk_p0_rem", remaining, 3);
    // pause
    run_ticks(1000);
    check("pz_rem_pre", remaining, 2);
    pause = 1;
    step();
    check("pz_paused", paused, 1);
    run_ticks(5000);
    check("pz_phase", phase, 0);
    check("pz_rem", remaining, 2);
    check("pz_paused2", paused, 1);
    pulse_next();
    check("pz_skip_phase", phase, 1);
    check("pz_skip_ps", phase_start, 1);
    check("pz_skip_rem", remaining, 1);
    pause = 0;
    step();
    check("pz_release", paused, 0);
    run_ticks(999);
    check("pz_res_phase", phase, 1);
    run_ticks(1);
    check("pz_res_adv", phase, 2);
    check("pz_res_rem", remaining, 2);
    // trim
    write(2, 63, 10'h0B2, 10'h092);
    check("tr_w63", cur_dur, 63);
    adj(1, 0);
    check("tr_inc_sat", cur_dur, 63);
    adj(0, 1);
    check("tr_dec", cur_dur, 62);
    adj(1, 0);
    check("tr_inc", cur_dur, 63);
    write(2, 1, 10'h0B2, 10'h092);
    check("tr_w1_rem", remaining, 1);
    adj(0, 1);
    check("tr_dec_sat", cur_dur, 1);
    adj(1, 1);
    check("tr_both", cur_dur, 1);
    adj(1, 0);
    check("tr_inc2", cur_dur, 2);
    check("tr_inc2_rem", remaining, 1);
    write(0, 5, 10'h3FF, 10'h000);
    pulse_next();
    check("tr5_phase", phase, 0);
    check("tr5_rem", remaining, 5);
    adj(0, 1);
    check("tr5_dec_dur", cur_dur, 4);
    check("tr5_dec_rem", remaining, 4);
    adj_dec = 1;
    write(0, 5, 10'h3FF, 10'h000);
    adj_dec = 0;
    check("tr_wr_wins", cur_dur, 5);
    check("tr_wr_rem", remaining, 4);
    // sequence length
    set_last(4'hF);
    repeat (15) pulse_next();
    check("sl_p15", phase, 15);
    pulse_next();
    check("sl_wrap15", phase, 0);
    repeat (7) pulse_next();
    check("sl_p7", phase, 7);
    set_last(3);
    check("sl_hold7", phase, 7);
    step();
    check("sl_clamp_phase", phase, 0);
    check("sl_clamp_ps", phase_start, 1);
    check("sl_clamp_rem", remaining, 5);
    repeat (3) pulse_next();
    check("sl_p3", phase, 3);
    pulse_next();
    check("sl_wrap3", phase, 0);
    // async reset mid-countdown
    run_ticks(500);
    #2;
    reset_n = 0;
    #1;
    check("ar_phase", phase, 0);
    check("ar_rem", remaining, 0);
    check("ar_cur", cur_dur, 0);
    check("ar_lights", lights, 0);
    #2;
    reset_n = 1;
    step();
    check("ar_init_ps", phase_start, 1);
    check("ar_init_rem", remaining, 1);
    step();
    check("ar_lights2", lights, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
